// File: rtl/bp_fe_scan_ctrl.sv
// Front-end scan controller: classifies fetched instructions, maintains a circular
// return-address stack and issues registered, held-until-accepted static redirects.

package bp_fe_scan_pkg;
    typedef enum logic [2:0] {
        e_rvc,
        e_rvi_call,
        e_rvi_ret,
        e_rvi_jal,
        e_rvi_branch,
        e_rvi_jalr,
        e_default
    } scan_class_e;
endpackage

module instr_scan
    import bp_fe_scan_pkg::*;
#(
    parameter int instr_width_p = 32
) (
    input  logic [instr_width_p-1:0] instr_i,
    output scan_class_e              scan_class_o,
    output logic [63:0]              imm_o
);
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       rd_link;
    logic       rs1_link;

    assign opcode   = instr_i[6:0];
    assign rd       = instr_i[11:7];
    assign rs1      = instr_i[19:15];
    assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        scan_class_o = e_default;
        imm_o        = '0;
        if (instr_i[1:0] != 2'b11) begin
            scan_class_o = e_rvc;
        end else begin
            case (opcode)
                7'b1101111: begin
                    imm_o = {{44{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
                    scan_class_o = rd_link ? e_rvi_call : e_rvi_jal;
                end
                7'b1100111: begin
                    imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
                    if (rd_link)
                        scan_class_o = e_rvi_call;
                    else if (rs1_link && (rd == 5'd0))
                        scan_class_o = e_rvi_ret;
                    else
                        scan_class_o = e_rvi_jalr;
                end
                7'b1100011: begin
                    imm_o = {{52{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
                    scan_class_o = e_rvi_branch;
                end
                default: ;
            endcase
        end
    end
endmodule

module bp_fe_scan_ctrl
    import bp_fe_scan_pkg::*;
#(
    parameter int eaddr_width_p = 64,
    parameter int instr_width_p = 32,
    parameter int ras_els_p     = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               fetch_v_i,
    input  logic [eaddr_width_p-1:0]           fetch_pc_i,
    input  logic [instr_width_p-1:0]           fetch_instr_i,
    output logic                               fetch_ready_o,
    input  logic                               flush_i,
    output logic                               redirect_v_o,
    output logic [eaddr_width_p-1:0]           redirect_pc_o,
    input  logic                               redirect_yumi_i,
    output logic [$clog2(ras_els_p+1)-1:0]     ras_count_o
);
    localparam int ptr_w_lp = $clog2(ras_els_p);
    localparam int cnt_w_lp = $clog2(ras_els_p + 1);

    typedef enum logic {e_idle, e_redirect} state_e;

    state_e                   state_r, state_n;
    scan_class_e              scan_class;
    logic [63:0]              scan_imm;
    logic                     accept;
    logic                     push, pop, redirect_load;
    logic [eaddr_width_p-1:0] redirect_target;
    logic [eaddr_width_p-1:0] pc_plus4, pc_plus_imm;
    logic [eaddr_width_p-1:0] redirect_pc_r;
    logic [ptr_w_lp-1:0]      tp_r, tp_inc, tp_dec;
    logic [cnt_w_lp-1:0]      count_r;
    logic [eaddr_width_p-1:0] ras_mem [ras_els_p];

    instr_scan #(.instr_width_p(instr_width_p)) scan (
        .instr_i      (fetch_instr_i),
        .scan_class_o (scan_class),
        .imm_o        (scan_imm)
    );

    assign fetch_ready_o = (state_r == e_idle) && !flush_i;
    assign accept        = fetch_v_i && fetch_ready_o;
    assign pc_plus4      = fetch_pc_i + eaddr_width_p'(4);
    assign pc_plus_imm   = fetch_pc_i + scan_imm[eaddr_width_p-1:0];
    assign tp_inc        = tp_r + ptr_w_lp'(1);
    assign tp_dec        = tp_r - ptr_w_lp'(1);

    assign redirect_v_o  = (state_r == e_redirect);
    assign redirect_pc_o = redirect_pc_r;
    assign ras_count_o   = count_r;

    always_comb begin
        state_n         = state_r;
        push            = 1'b0;
        pop             = 1'b0;
        redirect_load   = 1'b0;
        redirect_target = pc_plus_imm;
        case (state_r)
            e_idle: begin
                if (accept) begin
                    case (scan_class)
                        e_rvi_call: begin
                            push          = 1'b1;
                            redirect_load = (fetch_instr_i[6:0] == 7'b1101111);
                        end
                        e_rvi_ret: begin
                            if (count_r != '0) begin
                                pop             = 1'b1;
                                redirect_load   = 1'b1;
                                redirect_target = ras_mem[tp_r];
                            end
                        end
                        e_rvi_jal:    redirect_load = 1'b1;
                        e_rvi_branch: redirect_load = scan_imm[63];
                        default: ;
                    endcase
                end
                if (redirect_load)
                    state_n = e_redirect;
            end
            e_redirect: begin
                if (redirect_yumi_i)
                    state_n = e_idle;
            end
            default: state_n = e_idle;
        endcase
        // Flush overrides a concurrent yumi; accept is already blocked via fetch_ready_o.
        if (flush_i)
            state_n = e_idle;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state_r <= e_idle;
        else
            state_r <= state_n;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            redirect_pc_r <= '0;
            tp_r          <= '0;
            count_r       <= '0;
        end else begin
            if (redirect_load)
                redirect_pc_r <= redirect_target;
            if (push) begin
                tp_r <= tp_inc;
                if (count_r != cnt_w_lp'(ras_els_p))
                    count_r <= count_r + cnt_w_lp'(1);
            end else if (pop) begin
                tp_r    <= tp_dec;
                count_r <= count_r - cnt_w_lp'(1);
            end
        end
    end

    // NOTE: RAS storage has no reset; tp/count alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push)
            ras_mem[tp_inc] <= pc_plus4;
    end
endmodule
